// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-entry output slot to decode,
// execute-stage redirects and a sticky HALT on a configurable halt word.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_INST = 16'hF025
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_addr,
  input  logic [15:0] inst_in,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic [15:0] inst_count
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_ir_pc;
  logic        r_valid;
  logic [15:0] r_cnt;

  logic w_xfer;
  logic w_load;

  assign w_xfer = r_valid & out_ready;
  assign w_load = ~r_valid | w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_ir_pc <= 16'h0000;
      r_valid <= 1'b0;
      r_cnt   <= 16'h0000;
    end else begin
      if (w_xfer)
        r_cnt <= r_cnt + 16'd1;
      unique case (r_state)
        S_RUN: begin
          // redirect wins over a load; clearing bit 0 keeps the PC aligned
          if (br_taken) begin
            r_pc    <= br_target & 16'hFFFE;
            r_valid <= 1'b0;
          end else if (w_load) begin
            r_ir    <= inst_in;
            r_ir_pc <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + 16'd2;
            if (inst_in == HALT_INST)
              r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (w_xfer)
            r_valid <= 1'b0;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign pc_addr    = r_pc;
  assign ir         = r_ir;
  assign ir_pc      = r_ir_pc;
  assign out_valid  = r_valid;
  assign halted     = (r_state == S_HALT);
  assign inst_count = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// all checked cycle by cycle against a slot/queue reference model.
module tb_fetch_unit;

  localparam logic [15:0] HALT = 16'hF025;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] a;
  } ent_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        br_taken;
  logic        out_ready;
  logic [15:0] br_target;
  logic [15:0] inst_in;
  logic [15:0] pc_addr;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic [15:0] inst_count;
  logic        out_valid;
  logic        halted;

  logic [15:0] mem [0:32767];

  assign inst_in = mem[pc_addr[15:1]];

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .inst_in    (inst_in),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted),
    .inst_count (inst_count)
  );

  logic        rst_w;
  logic        rdy_w;
  logic        br_w;
  logic [15:0] tgt_w;
  logic [15:0] inst_w;
  logic [15:0] pc_w;
  logic [15:0] ir_w;
  logic [15:0] irpc_w;
  logic [15:0] cnt_w;
  logic        val_w;
  logic        hlt_w;

  assign inst_w = mem[pc_w[15:1]];

  fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk        (clk),
    .rst        (rst_w),
    .pc_addr    (pc_w),
    .inst_in    (inst_w),
    .br_taken   (br_w),
    .br_target  (tgt_w),
    .ir         (ir_w),
    .ir_pc      (irpc_w),
    .out_valid  (val_w),
    .out_ready  (rdy_w),
    .halted     (hlt_w),
    .inst_count (cnt_w)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_halt_dlv = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_irpc;
  logic [15:0] m_cnt;
  bit          m_halt;
  ent_t        m_q[$];

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Slot model: an entry leaves on transfer, an empty slot is refilled.
  task automatic model_update();
    bit          xf;
    logic [15:0] w;
    if (rst) begin
      m_pc   = 16'h0000;
      m_ir   = 16'h0000;
      m_irpc = 16'h0000;
      m_cnt  = 16'h0000;
      m_halt = 1'b0;
      m_q.delete();
      return;
    end
    xf = (m_q.size() != 0) && out_ready;
    if (xf) begin
      m_cnt = m_cnt + 16'd1;
      void'(m_q.pop_front());
    end
    if (m_halt) return;
    if (br_taken) begin
      m_pc = {br_target[15:1], 1'b0};
      m_q.delete();
      return;
    end
    if (m_q.size() == 0) begin
      w = mem[m_pc[15:1]];
      m_q.push_back('{w: w, a: m_pc});
      m_ir   = w;
      m_irpc = m_pc;
      m_pc   = m_pc + 16'd2;
      if (w == HALT) m_halt = 1'b1;
    end
  endtask

  task automatic step();
    bit hx;
    hx = out_valid && out_ready && (ir == HALT);
    @(posedge clk);
    model_update();
    if (hx) n_halt_dlv++;
    @(negedge clk);
    chk("pc_addr", pc_addr, m_pc);
    chk("out_valid", {15'd0, out_valid}, {15'd0, m_q.size() != 0});
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
    chk("halted", {15'd0, halted}, {15'd0, m_halt});
    chk("inst_count", inst_count, m_cnt);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    br_taken = 1'b0;
    br_target = 16'h0000;
    rst_w = 1'b1;
    rdy_w = 1'b1;
    br_w = 1'b0;
    tgt_w = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;

    // streaming
    mem[0] = 16'h1261;
    mem[1] = 16'h1482;
    mem[2] = 16'h0000;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_ir", ir, 16'h0000);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    rst = 1'b0;
    chk("rel_pc", pc_addr, 16'h0000);
    step();
    chk("s1_ir", ir, 16'h1261);
    chk("s1_pc", ir_pc, 16'h0000);
    step();
    chk("s2_ir", ir, 16'h1482);
    chk("s2_pc", ir_pc, 16'h0002);
    step();
    chk("s3_ir", ir, 16'h0000);
    chk("s3_pc", ir_pc, 16'h0004);
    step();
    chk("s_cnt", inst_count, 16'd3);

    // backpressure
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ir", ir, 16'h1261);
      chk("bp_irpc", ir_pc, 16'h0000);
      chk("bp_pc", pc_addr, 16'h0002);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_ir", ir, 16'h1482);
    chk("bp_rel_cnt", inst_count, 16'd1);

    // redirect
    mem[8] = 16'h2345;
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rd_pre_valid", {15'd0, out_valid}, 16'd1);
    br_taken = 1'b1;
    br_target = 16'h0011;
    step();
    chk("rd_valid", {15'd0, out_valid}, 16'd0);
    chk("rd_pc", pc_addr, 16'h0010);
    br_taken = 1'b0;
    step();
    chk("rd_irpc", ir_pc, 16'h0010);
    chk("rd_ir", ir, 16'h2345);

    // halt
    mem[3] = HALT;
    mem[4] = 16'h1111;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_halt_dlv = 0;
    for (int i = 0; i < 16; i++) begin
      out_ready = i[0];
      br_taken = (i == 8);
      br_target = 16'h0100;
      step();
    end
    br_taken = 1'b0;
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_pc", pc_addr, 16'h0008);
    chk("h_valid", {15'd0, out_valid}, 16'd0);
    chk("h_dlv", n_halt_dlv[15:0], 16'd1);
    chk("h_cnt", inst_count, 16'd4);

    // PC wrap from RESET_PC=FFFE, then reset under backpressure
    mem[16'h7FFF] = 16'h7777;
    step();
    rst_w = 1'b0;
    chk("w_rel_pc", pc_w, 16'hFFFE);
    step();
    chk("w_irpc0", irpc_w, 16'hFFFE);
    chk("w_ir0", ir_w, 16'h7777);
    step();
    chk("w_irpc1", irpc_w, 16'h0000);
    rdy_w = 1'b0;
    step();
    chk("w_valid", {15'd0, val_w}, 16'd1);
    chk("w_cnt_pre", cnt_w, 16'd1);
    rst_w = 1'b1;
    step();
    chk("w_rst_valid", {15'd0, val_w}, 16'd0);
    chk("w_rst_cnt", cnt_w, 16'd0);
    chk("w_rst_pc", pc_w, 16'hFFFE);

    // random traffic
    for (int i = 0; i < 32768; i++)
      mem[i] = ($urandom_range(0, 63) == 0) ? HALT : 16'($urandom);
    rst = 1'b1;
    step();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 9) == 0);
      br_target = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: byte address of the first instruction fetched after reset.
REQ-002 Parameter HALT_INST, default 16'hF025: instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_addr  output  16  byte address driven to the instruction memory; equals the internal PC.
REQ-006 inst_in  input  16  instruction word from the instruction memory for pc_addr, valid combinationally in the same cycle.
REQ-007 br_taken  input  1  redirect request from the execute stage.
REQ-008 br_target  input  16  redirect byte address; sampled only when br_taken=1.
REQ-009 ir  output  16  registered instruction presented to decode.
REQ-010 ir_pc  output  16  byte address from which ir was fetched.
REQ-011 out_valid  output  1  ir/ir_pc hold an instruction not yet accepted.
REQ-012 out_ready  input  1  decode accepts ir this cycle when out_valid=1.
REQ-013 halted  output  1  fetch is stopped in the HALT state.
REQ-014 inst_count  output  16  number of instructions accepted by decode since reset.

Function
REQ-015 States: RUN and HALT; there are no other states.
REQ-016 Transfer: a cycle with out_valid=1 and out_ready=1 is a transfer; inst_count increments by 1 on every transfer, wrapping 16'hFFFF->16'h0000.
REQ-017 Load: in RUN with br_taken=0, a load occurs when out_valid=0 or a transfer occurs.
REQ-018 On a load: ir<=inst_in, ir_pc<=pc, out_valid<=1, pc<=pc+2.
REQ-019 In RUN with br_taken=0 and no load, ir, ir_pc, out_valid and pc hold their values.
REQ-020 PC arithmetic is 16-bit unsigned; 16'hFFFE+2 wraps to 16'h0000.
REQ-021 In RUN with br_taken=1, the redirect has priority over a load.
REQ-022 On a redirect: pc<={br_target[15:1],1'b0}, out_valid<=0, and ir and ir_pc hold their values.
REQ-023 A transfer in the same cycle as a redirect still counts in inst_count.
REQ-024 When a load captures inst_in==HALT_INST, state goes to HALT on the same edge, and halted=1 from the next cycle.
REQ-025 In HALT: pc is frozen and no further loads occur.
REQ-026 In HALT: br_taken is ignored.
REQ-027 In HALT: out_valid stays 1 until the HALT word is transferred, then goes to 0 and remains 0.
REQ-028 Only rst exits HALT.
REQ-029 Latency: an instruction at address A appears on ir one cycle after pc_addr=A, if the output slot is free.
REQ-030 Sustained throughput is one instruction per cycle while out_ready=1 and there is no redirect.

Reset
REQ-031 When rst=1 at a rising edge, the block enters the following state regardless of any other input: pc=RESET_PC, ir=16'h0000, ir_pc=16'h0000, out_valid=0, inst_count=0, halted=0, state=RUN.
REQ-032 When rst is asserted mid-stall or during HALT, any pending ir is discarded.
REQ-033 In the first cycle after reset release: pc_addr=RESET_PC, out_valid=0, and a load occurs on that cycle's edge.

Verification
REQ-034 Streaming: rst for 2 cycles, memory words 16'h1261, 16'h1482, 16'h0000 at 0/2/4, out_ready=1. Required: ir/ir_pc sequence is (1261,0000), (1482,0002), (0000,0004) on consecutive cycles; inst_count=3 after the third transfer.
REQ-035 Backpressure: out_ready=0 for 3 cycles with ir=16'h1261 valid. Required: ir, ir_pc and pc_addr=0002 are stable for all 3 cycles; release gives ir=16'h1482 one cycle later, with no word lost or duplicated.
REQ-036 Redirect: br_taken=1 with br_target=16'h0011 while out_valid=1. Required: out_valid=0 next cycle, pc_addr=16'h0010, and the following ir_pc=16'h0010.
REQ-037 Halt: 16'hF025 at address 6 and out_ready toggling. Required: halted=1 after the HALT load; the HALT word is delivered exactly once, then out_valid=0 permanently; br_taken pulse has no effect; pc_addr stays 16'h0008.
REQ-038 Wrap and reset: RESET_PC=16'hFFFE. Required: ir_pc sequence is FFFE, then 0000. Asserting rst with out_valid=1 and out_ready=0 gives out_valid=0 and inst_count=0 next cycle.
